// File: rtl/tdo_uart_tx.sv
// Scan-chain TDO capture into bytes (LSB first), small byte FIFO, 8N1 UART back to the host.
// Optional TX_PARITY_EN macro adds an even-parity bit per frame (8E1).
module tdo_uart_tx #(
  parameter int CLKRATE    = 12_000_000,
  parameter int BAUDRATE   = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rtck,
  input  logic tdo,
  input  logic tms,
  output logic tx,
  output logic busy,
  output logic overflow
);

  localparam int DIV = CLKRATE / BAUDRATE;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW  = $clog2(DIV);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic rtck_s1, rtck_s2, rtck_s3;
  logic tdo_s1, tdo_s2;
  logic tms_s1, tms_s2;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic rtck_rise, push, pop, push_ok;
  logic [7:0] push_dat;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;

  state_t state;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] tx_sh;
`ifdef TX_PARITY_EN
  logic par;
`endif

  assign rtck_rise = rtck_s2 & ~rtck_s3;
  // Bits 0..6 sit in sh; bit 7 is the live sample on the completing edge.
  assign push     = tms_s2 & rtck_rise & (cnt == 3'd7);
  assign push_dat = {tdo_s2, sh};
  assign pop      = (state == IDLE) & (count != '0);
  assign push_ok  = push & ((count != DEPTH_C) | pop);
  assign busy     = (state != IDLE) | (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rtck_s1 <= 1'b0; rtck_s2 <= 1'b0; rtck_s3 <= 1'b0;
      tdo_s1  <= 1'b0; tdo_s2  <= 1'b0;
      tms_s1  <= 1'b0; tms_s2  <= 1'b0;
      cnt     <= 3'd0;
      sh      <= 7'd0;
    end else begin
      rtck_s1 <= rtck; rtck_s2 <= rtck_s1; rtck_s3 <= rtck_s2;
      tdo_s1  <= tdo;  tdo_s2  <= tdo_s1;
      tms_s1  <= tms;  tms_s2  <= tms_s1;
      if (!tms_s2) begin
        cnt <= 3'd0;
      end else if (rtck_rise) begin
        cnt <= cnt + 3'd1;
        sh  <= {tdo_s2, sh[6:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // tx is registered: every state drives the level for the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= 3'd0;
      tx_sh   <= 8'd0;
`ifdef TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            tx_sh <= mem[rd_ptr];
`ifdef TX_PARITY_EN
            par   <= ^mem[rd_ptr];
`endif
            baud  <= BAUD_LOAD;
            state <= START;
            tx    <= 1'b0;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          if (baud == '0) begin
            state   <= DATA;
            tx      <= tx_sh[0];
            bit_idx <= 3'd0;
            baud    <= BAUD_LOAD;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= tx_sh[1];
              tx_sh   <= {1'b0, tx_sh[7:1]};
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
`ifdef TX_PARITY_EN
        PARITY: begin
          if (baud == '0) begin
            state <= STOP;
            tx    <= 1'b1;
            baud  <= BAUD_LOAD;
          end else begin
            baud <= baud - 1'b1;
          end
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (baud == '0) state <= IDLE;
          else            baud  <= baud - 1'b1;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdo_uart_tx.sv
// Directed bench for tdo_uart_tx: reset, single byte, partial-byte clear, back-to-back,
// FIFO overflow, mid-frame reset, and parity frames when TX_PARITY_EN is defined.
module tb_tdo_uart_tx;

  localparam int DIV = 104;

  logic clk, rst, rtck, tdo, tms;
  logic tx, busy, overflow;
  int tests = 0;
  int fails = 0;

  tdo_uart_tx #(.CLKRATE(12_000_000), .BAUDRATE(115_200), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rtck(rtck), .tdo(tdo), .tms(tms),
    .tx(tx), .busy(busy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n rtck pulses, tdo carrying b LSB first, hp cycles high and hp cycles low.
  task automatic send_bits(input logic [7:0] b, input int n, input int hp);
    for (int i = 0; i < n; i++) begin
      tdo  = b[i];
      rtck = 1'b1;
      repeat (hp) @(negedge clk);
      rtck = 1'b0;
      repeat (hp) @(negedge clk);
    end
  endtask

  task automatic wait_start();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        seen = 1;
        break;
      end
    end
    check("start_timeout", seen, 1);
  endtask

  task automatic quiet(input string tag, input int n);
    bit saw;
    saw = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) saw = 1;
    end
    check(tag, saw, 0);
  endtask

  // Checks first and last cycle of every bit, then the cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input bit do_wait, input bit expect_idle);
    logic [10:0] bits;
    int nb;
`ifdef TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
    nb   = 11;
`else
    bits = {1'b0, 1'b1, b, 1'b0};
    nb   = 10;
`endif
    if (do_wait) wait_start();
    check("frame_busy", busy, 1);
    for (int k = 0; k < nb; k++) begin
      check($sformatf("byte%02h_bit%0d_first", b, k), tx, bits[k]);
      repeat (DIV - 1) @(negedge clk);
      check($sformatf("byte%02h_bit%0d_last", b, k), tx, bits[k]);
      @(negedge clk);
    end
    check("after_stop_tx", tx, 1);
    check("after_stop_busy", busy, expect_idle ? 0 : 1);
  endtask

  initial begin
    rst = 1'b1; rtck = 1'b0; tdo = 1'b0; tms = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      rtck = ~rtck;
    end
    rtck = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // tms low: edges ignored, nothing transmitted
    fork
      send_bits(8'hFF, 8, 20);
      quiet("no_start_tms_low", 2000);
    join
    check("idle_busy", busy, 0);

    tms = 1'b1;
    repeat (5) @(negedge clk);

    fork
      send_bits(8'hA5, 8, 20);
      check_frame(8'hA5, 1, 1);
    join

    fork
      begin
        send_bits(8'hFF, 5, 20);
        tms = 1'b0;
        repeat (10) @(negedge clk);
        tms = 1'b1;
        repeat (5) @(negedge clk);
        send_bits(8'h3C, 8, 20);
      end
      begin
        check_frame(8'h3C, 1, 1);
        quiet("partial_single_frame", 300);
      end
    join

    fork
      begin
        send_bits(8'h01, 8, 4);
        send_bits(8'h80, 8, 4);
      end
      begin
        check_frame(8'h01, 1, 0);
        @(negedge clk);
        check_frame(8'h80, 0, 1);
      end
    join
    check("no_overflow_yet", overflow, 0);

    fork
      begin
        for (int k = 0; k < 6; k++) send_bits(8'(8'h10 + k), 8, 4);
      end
      begin
        check_frame(8'h10, 1, 0);
        for (int j = 1; j < 5; j++) begin
          @(negedge clk);
          check_frame(8'(8'h10 + j), 0, j == 4);
        end
      end
    join
    quiet("dropped_byte_absent", 300);
    check("overflow_sticky", overflow, 1);

    fork
      send_bits(8'h5A, 8, 4);
      begin
        wait_start();
        repeat (300) @(negedge clk);
      end
    join
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_overflow", overflow, 0);
    rst = 1'b0;
    quiet("no_resume_after_rst", 1200);

`ifdef TX_PARITY_EN
    repeat (5) @(negedge clk);
    fork
      send_bits(8'h07, 8, 20);
      check_frame(8'h07, 1, 1);
    join
    fork
      send_bits(8'h03, 8, 20);
      check_frame(8'h03, 1, 1);
    join
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
